// File: rtl/ascon_pkg.sv
// Shared types and constants for the Ascon permutation arbiter.
// Holds the arbiter FSM state encoding and the legal round counts.
package ascon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic [3:0] ROUNDS_P12 = 4'd12;
    localparam logic [3:0] ROUNDS_P8  = 4'd8;
    localparam logic [3:0] ROUNDS_P6  = 4'd6;

    function automatic logic rounds_legal(input logic [3:0] rounds);
        return (rounds == ROUNDS_P12) || (rounds == ROUNDS_P8) || (rounds == ROUNDS_P6);
    endfunction

endpackage

// File: rtl/ascon_rr_pick.sv
// Combinational round-robin picker: finds the first set bit of req,
// searching upward from ptr and wrapping past NUM_REQ-1 back to 0.
module ascon_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       valid,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int IW = $clog2(NUM_REQ);
    localparam logic [IW:0] NUM_REQ_W = (IW+1)'(NUM_REQ);

    logic [IW:0]   sum  [NUM_REQ];
    logic [IW-1:0] cand [NUM_REQ];
    logic [NUM_REQ-1:0] hit;

    // Offset gi from the pointer maps to requester (ptr + gi) mod NUM_REQ.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign sum[gi]  = {1'b0, ptr} + (IW+1)'(gi);
            assign cand[gi] = (sum[gi] >= NUM_REQ_W) ? IW'(sum[gi] - NUM_REQ_W) : IW'(sum[gi]);
            assign hit[gi]  = req[cand[gi]];
        end
    endgenerate

    always_comb begin
        valid = |hit;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                idx = cand[k];
            end
        end
    end

endmodule

// File: rtl/ascon_perm_arbiter.sv
// Round-robin arbiter sharing one Ascon permutation engine among NUM_REQ requesters.
// Define ASCON_ARB_WDOG_EN to abort WAIT after WDOG_CYCLES cycles without perm_done.
module ascon_perm_arbiter
    import ascon_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*4-1:0]       req_rounds,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic                       rsp_err,
    output logic                       perm_start,
    output logic [3:0]                 perm_rounds,
    input  logic                       perm_busy,
    input  logic                       perm_done,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       arb_busy,
    output logic                       err
);

    localparam int IW = $clog2(NUM_REQ);
    localparam logic [IW:0] NUM_REQ_W = (IW+1)'(NUM_REQ);
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

`ifdef ASCON_ARB_WDOG_EN
    localparam bit WDOG_EN = 1'b1;
`else
    localparam bit WDOG_EN = 1'b0;
`endif

    arb_state_t state_reg, state_next;

    logic [IW-1:0]     grant_reg;
    logic [IW-1:0]     rr_ptr_reg;
    logic [3:0]        rounds_reg;
    logic              legal_reg;
    logic              op_err_reg;
    logic              err_reg;
    logic [WDOG_W-1:0] wdog_cnt_reg;

    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic [3:0]    rounds_slice [NUM_REQ];
    logic [3:0]    win_rounds;
    logic          accept;
    logic          in_resp;
    logic          wdog_hit;
    logic [IW:0]   grant_inc;
    logic [IW-1:0] rr_next;

    ascon_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_reg),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign rounds_slice[gi] = req_rounds[4*gi +: 4];
        end
    endgenerate

    assign win_rounds = rounds_slice[pick_idx];
    assign wdog_hit   = WDOG_EN && (wdog_cnt_reg == WDOG_LAST);
    assign grant_inc  = {1'b0, grant_reg} + (IW+1)'(1);
    assign rr_next    = (grant_inc == NUM_REQ_W) ? '0 : grant_inc[IW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (pick_valid) state_next = ISSUE;
            ISSUE: begin
                if (!legal_reg) begin
                    state_next = RESP;
                end else if (!perm_busy) begin
                    state_next = WAIT;
                end
            end
            WAIT:  if (perm_done || wdog_hit) state_next = RESP;
            RESP:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pulses are masked during reset so nothing leaks out while the FSM is being cleared.
    always_comb begin
        accept     = !rst && (state_reg == IDLE) && pick_valid;
        perm_start = !rst && (state_reg == ISSUE) && legal_reg && !perm_busy;
        in_resp    = !rst && (state_reg == RESP);
        rsp_err    = in_resp && op_err_reg;
        arb_busy   = (state_reg != IDLE);
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign req_ready[gi] = accept  && (pick_idx  == IW'(gi));
            assign rsp_valid[gi] = in_resp && (grant_reg == IW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_reg    <= '0;
            rr_ptr_reg   <= '0;
            rounds_reg   <= '0;
            legal_reg    <= 1'b0;
            op_err_reg   <= 1'b0;
            err_reg      <= 1'b0;
            wdog_cnt_reg <= '0;
        end else begin
            if (accept) begin
                grant_reg  <= pick_idx;
                rounds_reg <= win_rounds;
                legal_reg  <= rounds_legal(win_rounds);
                op_err_reg <= !rounds_legal(win_rounds);
            end
            if ((state_reg == ISSUE) && !perm_busy) begin
                wdog_cnt_reg <= '0;
            end
            if (state_reg == WAIT) begin
                if (wdog_cnt_reg != WDOG_LAST) begin
                    wdog_cnt_reg <= wdog_cnt_reg + WDOG_W'(1);
                end
                // A completion arriving on the timeout cycle still counts as success.
                if (!perm_done && wdog_hit) begin
                    op_err_reg <= 1'b1;
                end
            end
            if (state_reg == RESP) begin
                rr_ptr_reg <= rr_next;
                if (op_err_reg) begin
                    err_reg <= 1'b1;
                end
            end
        end
    end

    assign grant_id    = grant_reg;
    assign perm_rounds = rounds_reg;
    assign err         = err_reg;

endmodule

// File: tb/tb_ascon_perm_arbiter.sv
// Self-checking bench for ascon_perm_arbiter (NUM_REQ=4, WDOG_CYCLES=64).
// Transaction-level model compared every cycle plus directed literal checks.
module tb_ascon_perm_arbiter;

    localparam int N    = 4;
    localparam int WDOG = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req_valid;
    logic [N*4-1:0] req_rounds;
    logic [N-1:0] req_ready;
    logic [N-1:0] rsp_valid;
    logic         rsp_err;
    logic         perm_start;
    logic [3:0]   perm_rounds;
    logic         perm_busy;
    logic         perm_done;
    logic [1:0]   grant_id;
    logic         arb_busy;
    logic         err;

    ascon_perm_arbiter #(.NUM_REQ(N), .WDOG_CYCLES(WDOG)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_rounds(req_rounds),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .perm_start(perm_start), .perm_rounds(perm_rounds), .perm_busy(perm_busy),
        .perm_done(perm_done), .grant_id(grant_id), .arb_busy(arb_busy), .err(err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // event log filled by the monitor
    int ready_count = 0, start_count = 0, rsp_count = 0;
    int ready_cyc = -1, start_cyc = -1, rsp_cyc = -1, done_cyc = -1;
    int start_rounds = -1, rsp_idx = -1, rsp_err_last = -1;
    int grants[$];
    int rsps[$];

    // transaction model
    bit m_active = 0, m_started = 0, m_finished = 0, m_legal = 0, m_fail = 0, m_err = 0;
    int m_owner = 0, m_rounds = 0, m_rr = 0, m_wait = 0;

    // engine stub
    int eng_latency = 12, eng_cnt = 0, eng_seen = 0;
    bit eng_respond = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic int pick(input int rr, input logic [N-1:0] rv);
        for (int k = 0; k < N; k++) begin
            if (rv[(rr + k) % N]) return (rr + k) % N;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic bit legal(input int r);
        return (r == 6) || (r == 8) || (r == 12);
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // compare + model advance, once per cycle on the falling edge
    initial forever begin
        logic [N-1:0] exp_ready, exp_rsp;
        logic exp_start, exp_rsp_err;
        int w;
        @(negedge clk);
        exp_ready = '0; exp_rsp = '0; exp_start = 1'b0; exp_rsp_err = 1'b0;
        w = pick(m_rr, req_valid);
        if (!rst) begin
            if (!m_active) begin
                if (w >= 0) exp_ready[w] = 1'b1;
            end else if (m_finished) begin
                exp_rsp[m_owner] = 1'b1;
                exp_rsp_err = m_fail;
            end else if (!m_started && m_legal && !perm_busy) begin
                exp_start = 1'b1;
            end
        end
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("perm_start", 32'(perm_start), 32'(exp_start));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
        chk("rsp_err", 32'(rsp_err), 32'(exp_rsp_err));
        chk("grant_id", 32'(grant_id), 32'(m_owner));
        chk("perm_rounds", 32'(perm_rounds), 32'(m_rounds));
        chk("arb_busy", 32'(arb_busy), 32'(m_active));
        chk("err", 32'(err), 32'(m_err));

        if (req_ready != 0) begin
            ready_count++; ready_cyc = cyc; grants.push_back(onehot_idx(req_ready));
            $display("cycle %0d: grant req=%0d rounds=%0d", cyc, onehot_idx(req_ready),
                     req_rounds[4*onehot_idx(req_ready) +: 4]);
        end
        if (perm_start) begin
            start_count++; start_cyc = cyc; start_rounds = perm_rounds;
            $display("cycle %0d: perm_start rounds=%0d", cyc, perm_rounds);
        end
        if (perm_done) done_cyc = cyc;
        if (rsp_valid != 0) begin
            rsp_count++; rsp_cyc = cyc; rsp_idx = onehot_idx(rsp_valid); rsp_err_last = rsp_err;
            rsps.push_back(rsp_idx);
            $display("cycle %0d: response req=%0d err=%0d", cyc, rsp_idx, rsp_err);
        end

        if (rst) begin
            m_active = 0; m_started = 0; m_finished = 0; m_fail = 0; m_err = 0;
            m_owner = 0; m_rounds = 0; m_rr = 0; m_wait = 0; m_legal = 0;
        end else if (!m_active) begin
            if (w >= 0) begin
                m_active = 1; m_started = 0; m_finished = 0; m_owner = w;
                m_rounds = req_rounds[4*w +: 4]; m_legal = legal(m_rounds); m_fail = 0;
            end
        end else if (m_finished) begin
            m_active = 0; m_finished = 0;
            if (m_fail) m_err = 1;
            m_rr = (m_owner + 1) % N;
        end else if (!m_started) begin
            if (!m_legal) begin
                m_finished = 1; m_fail = 1;
            end else if (!perm_busy) begin
                m_started = 1; m_wait = 0;
            end
        end else begin
            if (perm_done) begin
                m_finished = 1; m_fail = 0;
            end
`ifdef ASCON_ARB_WDOG_EN
            else if (m_wait == WDOG - 1) begin
                m_finished = 1; m_fail = 1;
            end
`endif
            else m_wait++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        perm_done = 1'b0;
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0 && eng_respond) perm_done = 1'b1;
        end
        if (start_count != eng_seen) begin
            eng_seen = start_count;
            eng_cnt = eng_latency - 1;
        end
    endtask

    task automatic run_to_rsp(input int target, input int budget, input bit drop);
        int base = ready_count;
        int n = 0;
        while (rsp_count < target && n < budget) begin
            step();
            n++;
            if (drop && ready_count > base) req_valid = '0;
        end
        chk("rsp_arrived", rsp_count, target);
    endtask

    task automatic wait_start(input int target, input int budget);
        int base = ready_count;
        int n = 0;
        while (start_count < target && n < budget) begin
            step();
            n++;
            if (ready_count > base) req_valid = '0;
        end
        chk("start_arrived", start_count, target);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
    endtask

    initial begin
        int base, r0;
        rst = 1'b1; req_valid = '0; req_rounds = '0; perm_busy = 1'b0; perm_done = 1'b0;
        step(); step(); step();
        chk("reset_arb_busy", arb_busy, 0);
        chk("reset_grant_id", grant_id, 0);
        chk("reset_perm_rounds", perm_rounds, 0);
        chk("reset_err", err, 0);
        rst = 1'b0;
        step();

        // single request, 12 rounds, done 12 cycles after start
        eng_latency = 12;
        req_rounds[3:0] = 4'd12;
        req_valid = 4'b0001;
        run_to_rsp(1, 60, 1'b1);
        chk("t1_start_latency", start_cyc - ready_cyc, 1);
        chk("t1_perm_rounds", start_rounds, 12);
        chk("t1_done_after_start", done_cyc - start_cyc, 12);
        chk("t1_rsp_latency", rsp_cyc - done_cyc, 1);
        chk("t1_rsp_idx", rsp_idx, 0);
        chk("t1_rsp_err", rsp_err_last, 0);

        // all four continuously from reset
        req_valid = 4'b1111;
        req_rounds = {4'd8, 4'd6, 4'd12, 4'd8};
        eng_latency = 4;
        do_reset();
        base = grants.size();
        r0 = rsps.size();
        run_to_rsp(rsp_count + 5, 200, 1'b0);
        req_valid = '0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_grant_order", grants[base + i], i % 4);
            chk("t2_rsp_order", rsps[r0 + i], i % 4);
        end

        // illegal round count on requester 2
        step();
        base = start_count;
        req_rounds[11:8] = 4'd5;
        req_valid = 4'b0100;
        run_to_rsp(rsp_count + 1, 40, 1'b1);
        chk("t3_ready_idx", grants[grants.size() - 1], 2);
        chk("t3_no_start", start_count, base);
        chk("t3_rsp_idx", rsp_idx, 2);
        chk("t3_rsp_err", rsp_err_last, 1);
        chk("t3_err_flag", err, 1);

        // engine busy for 3 ISSUE cycles, stray perm_done during ISSUE
        step();
        eng_latency = 5;
        req_rounds[7:4] = 4'd6;
        req_valid = 4'b0010;
        perm_busy = 1'b1;
        step();
        req_valid = '0;
        step();
        perm_done = 1'b1;
        step();
        step();
        perm_busy = 1'b0;
        run_to_rsp(rsp_count + 1, 40, 1'b1);
        chk("t4_start_delay", start_cyc - ready_cyc, 4);
        chk("t4_rsp_idx", rsp_idx, 1);
        chk("t4_rsp_err", rsp_err_last, 0);
        chk("t4_rsp_after_done", rsp_cyc - done_cyc, 1);

        // reset while waiting abandons the operation
        step();
        eng_latency = 12;
        req_rounds[15:12] = 4'd12;
        req_valid = 4'b1000;
        wait_start(start_count + 1, 20);
        step(); step();
        base = rsp_count;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_idle_after_rst", arb_busy, 0);
        chk("t5_err_cleared", err, 0);
        repeat (20) step();
        chk("t5_no_rsp", rsp_count, base);

`ifdef ASCON_ARB_WDOG_EN
        // engine never completes: watchdog fires after 64 WAIT cycles
        eng_respond = 1'b0;
        req_rounds[3:0] = 4'd8;
        req_valid = 4'b0001;
        run_to_rsp(rsp_count + 1, 200, 1'b1);
        chk("t6_wdog_latency", rsp_cyc - start_cyc, WDOG + 1);
        chk("t6_rsp_err", rsp_err_last, 1);
        chk("t6_err_flag", err, 1);
        chk("t6_idle", arb_busy, 0);
        req_rounds[7:4] = 4'd6;
        req_valid = 4'b0010;
        wait_start(start_count + 1, 20);
        repeat (5) step();
        base = rsp_count;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_idle_after_rst", arb_busy, 0);
        chk("t6_err_cleared", err, 0);
        repeat (5) step();
        chk("t6_no_rsp", rsp_count, base);
        eng_respond = 1'b1;
`endif

        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout cycle=%0d actual=running required=finished", cyc);
        $fatal(1, "timeout");
    end

endmodule
